adc_acq_wingen_mc: RTL and testbench
====================================

Name: adc_acq_wingen_mc

Overview:
Parametrised successor to the single-echo ADC acquisition window generator. It converts the pulse-sequencer ACQ_WND into a programmable-delay, decimated sample-strobe train (ACQ_EN) for the ADC capture path. It also counts echoes across a CPMG train and reports train completion and window-timing faults. It sits between the pulse sequencer and the ADC FIFO write logic.

Parameters:
SAMPLES_PER_ECHO_WIDTH, 32, width of per-echo sample count
ADC_INIT_DELAY_WIDTH, 32, width of initial delay count (clock cycles)
DECIM_WIDTH, 8, width of decimation stride
ECHO_CNT_WIDTH, 16, width of echo count and index

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
ADC_INIT_DELAY  in  ADC_INIT_DELAY_WIDTH  cycles from window rise to first strobe
SAMPLES_PER_ECHO  in  SAMPLES_PER_ECHO_WIDTH  strobes per echo
DECIM  in  DECIM_WIDTH  cycles between strobes; 0 is treated as 1
NUM_ECHOES  in  ECHO_CNT_WIDTH  echoes per train; 0 means unbounded
TRUNC_MODE  in  1  1 = abort the echo on window fall; 0 = finish the sample count
ERR_CLR  in  1  clears the sticky error flags
ACQ_WND  in  1  acquisition window from the sequencer
ACQ_EN  out  1  one-cycle sample strobe
ACQ_GATE  out  1  high from the first strobe through the last strobe of an echo
BUSY  out  1  state is not IDLE
ECHO_DONE  out  1  one-cycle pulse at echo end
TRAIN_DONE  out  1  one-cycle pulse at the last echo of a train
ECHO_IDX  out  ECHO_CNT_WIDTH  echoes completed in the current train
ERR_SHORT_WND  out  1  sticky: window fell before the last strobe
ERR_OVERLAP  out  1  sticky: window rose while an echo was active

Behaviour:
- Clock and reset: single clock CLK. RESET is synchronous and active-high. Reset applies on the next edge regardless of state, including mid-acquisition: state to IDLE, all outputs 0, counters 0.
- Edge detection: register ACQ_WND. A rise is detected in cycle t when ACQ_WND=1 and the previous sample was 0.
- Parameter latch: ADC_INIT_DELAY, SAMPLES_PER_ECHO, DECIM and TRUNC_MODE are latched at the rise. Changes during an echo have no effect. NUM_ECHOES is latched at the first echo of a train.
- States: IDLE, DELAY, ACQ, DRAIN.
  - IDLE -> DELAY on a rise; the delay counter is loaded with D = ADC_INIT_DELAY.
  - DELAY: decrements each cycle; at 0 -> ACQ.
  - ACQ: sample counter S and stride counter R.
  - DRAIN: one cycle that issues ECHO_DONE and updates the echo count, then -> IDLE.
- Strobe timing:
  - First ACQ_EN at cycle t+1+D; D=0 gives the first strobe at t+1.
  - Subsequent strobes every max(DECIM,1) cycles.
  - With DECIM=1, ACQ_EN is a continuous level of S cycles, which preserves predecessor behaviour.
  - ACQ_GATE is high from the first strobe through the last strobe inclusive.
- Echo end: ECHO_DONE is asserted in the cycle after the last strobe.
- SAMPLES_PER_ECHO=0: no strobes and no delay; ECHO_DONE at t+1, and the echo is counted.
- Window fall before the last strobe:
  - ERR_SHORT_WND is set in both modes.
  - TRUNC_MODE=1: no strobe in the cycle ACQ_WND is sampled low. The state goes to DRAIN and ECHO_DONE still pulses.
  - TRUNC_MODE=0: strobes continue to the full count.
- Rise while not IDLE (only possible when TRUNC_MODE=0): the rise is ignored and ERR_OVERLAP is set.
- Rise in the same cycle as DRAIN: ignored and flagged as overlap. Sequencer spacing must be at least one idle cycle.
- Echo counting:
  - ECHO_IDX increments in the ECHO_DONE cycle.
  - If NUM_ECHOES≠0 and the increment reaches NUM_ECHOES, TRAIN_DONE pulses in the same cycle and ECHO_IDX returns to 0.
  - NUM_ECHOES=0: TRAIN_DONE never asserts and ECHO_IDX wraps modulo 2^ECHO_CNT_WIDTH.
- Error flags: sticky until ERR_CLR or RESET. If ERR_CLR and a set condition occur in the same cycle, set wins.
- Arithmetic: counters are unsigned and are never decremented below 0; there is no wrap in DELAY or ACQ.

Decomposition:
- Package adc_acq_pkg holds:
  - the state enum (IDLE, DELAY, ACQ, DRAIN);
  - default width constants;
  - the function eff_decim(d), which returns 1 if d==0, else d.
- Sub-module adc_acq_strobe_gen holds the stride counter and strobe generation (inputs: start, decim, stop; output: strobe). The top module keeps the FSM, sample count, echo count and flags.

Test Plan:
- Baseline: D=2, S=10, DECIM=1, NUM_ECHOES=2; ACQ_WND rises at t and stays high 100 cycles. Required: ACQ_EN high t+3..t+12, ECHO_DONE at t+13, ECHO_IDX=1. The second window gives TRAIN_DONE and ECHO_IDX=0.
- Decimation: D=0, S=4, DECIM=3. Required: strobes at t+1, t+4, t+7, t+10; ACQ_GATE high t+1..t+10; ECHO_DONE at t+11.
- Truncation: TRUNC_MODE=1, D=2, S=10, window high 6 cycles. Required: strobes t+3..t+5 only, ECHO_DONE pulses, ERR_SHORT_WND=1. ERR_CLR then clears it.
- Overlap: TRUNC_MODE=0, S=20, window high 5 cycles, low 2, high again. Required: all 20 strobes issue, second rise ignored, ERR_OVERLAP=1 and ERR_SHORT_WND=1.
- Edge cases: S=0 gives ECHO_DONE at t+1 with no strobe. DECIM=0 behaves as 1. NUM_ECHOES=0 over 3 echoes gives ECHO_IDX=3 and no TRAIN_DONE.
- Reset mid-ACQ: RESET asserted at strobe 5. Required: the next cycle has all outputs 0 and state IDLE; a following rise starts a fresh echo with ECHO_IDX=0.

Source files
------------

// File: rtl/adc_acq_pkg.sv
// Shared types, default widths and helpers for the ADC acquisition window generator.
package adc_acq_pkg;

  localparam int SPE_W_DEF     = 32;
  localparam int ADC_DLY_W_DEF = 32;
  localparam int DECIM_W_DEF   = 8;
  localparam int ECHO_W_DEF    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ACQ   = 2'd2,
    ST_DRAIN = 2'd3
  } acq_state_t;

  // A stride of zero would never produce a second strobe, so it is treated as one.
  function automatic logic [31:0] eff_decim(input logic [31:0] d);
    logic [31:0] v;
    if (d == 32'd0) begin
      v = 32'd1;
    end else begin
      v = d;
    end
    return v;
  endfunction

endpackage

// File: rtl/adc_acq_strobe_gen.sv
// Stride counter producing the decimated sample strobe once an echo starts sampling.
module adc_acq_strobe_gen
#(
  parameter int DECIM_WIDTH = 8
)
(
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [DECIM_WIDTH-1:0] i_decim,
  input  logic                   i_stop,
  output logic                   o_strobe
);

  logic                   r_active;
  logic                   r_strobe;
  logic [DECIM_WIDTH-1:0] r_cnt;

  // Start issues a strobe in the next cycle; r_cnt then counts down the cycles to the next one.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active <= 1'b0;
      r_strobe <= 1'b0;
      r_cnt    <= '0;
    end else if (i_stop) begin
      r_active <= 1'b0;
      r_strobe <= 1'b0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_strobe <= 1'b1;
      r_cnt    <= i_decim;
    end else if (r_active) begin
      if ((r_cnt == DECIM_WIDTH'(0)) || (r_cnt == DECIM_WIDTH'(1))) begin
        r_strobe <= 1'b1;
        r_cnt    <= i_decim;
      end else begin
        r_strobe <= 1'b0;
        r_cnt    <= r_cnt - DECIM_WIDTH'(1);
      end
    end else begin
      r_strobe <= 1'b0;
      r_cnt    <= '0;
    end
  end

  assign o_strobe = r_strobe;

endmodule

// File: rtl/adc_acq_wingen_mc.sv
// Converts the sequencer acquisition window into a delayed, decimated ADC sample-strobe
// train, counts echoes across a CPMG train and keeps sticky window-timing fault flags.
module adc_acq_wingen_mc
  import adc_acq_pkg::*;
#(
  parameter int SAMPLES_PER_ECHO_WIDTH = SPE_W_DEF,
  parameter int ADC_INIT_DELAY_WIDTH   = ADC_DLY_W_DEF,
  parameter int DECIM_WIDTH            = DECIM_W_DEF,
  parameter int ECHO_CNT_WIDTH         = ECHO_W_DEF
)
(
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic [ADC_INIT_DELAY_WIDTH-1:0]   i_adc_init_delay,
  input  logic [SAMPLES_PER_ECHO_WIDTH-1:0] i_samples_per_echo,
  input  logic [DECIM_WIDTH-1:0]            i_decim,
  input  logic [ECHO_CNT_WIDTH-1:0]         i_num_echoes,
  input  logic                              i_trunc_mode,
  input  logic                              i_err_clr,
  input  logic                              i_acq_wnd,
  output logic                              o_acq_en,
  output logic                              o_acq_gate,
  output logic                              o_busy,
  output logic                              o_echo_done,
  output logic                              o_train_done,
  output logic [ECHO_CNT_WIDTH-1:0]         o_echo_idx,
  output logic                              o_err_short_wnd,
  output logic                              o_err_overlap
);

  acq_state_t                        r_state;
  logic                              r_wnd_prev;
  logic [ADC_INIT_DELAY_WIDTH-1:0]   r_delay;
  logic [SAMPLES_PER_ECHO_WIDTH-1:0] r_left;
  logic [DECIM_WIDTH-1:0]            r_decim;
  logic                              r_trunc;
  logic [ECHO_CNT_WIDTH-1:0]         r_num;
  logic [ECHO_CNT_WIDTH-1:0]         r_echo_idx;
  logic                              r_echo_done;
  logic                              r_train_done;
  logic                              r_gate;
  logic                              r_err_short;
  logic                              r_err_overlap;

  logic                              w_idle;
  logic                              w_rise;
  logic [DECIM_WIDTH-1:0]            w_decim_in;
  logic [DECIM_WIDTH-1:0]            w_decim;
  logic                              w_strobe;
  logic                              w_cut;
  logic                              w_abort_dly;
  logic                              w_start;
  logic                              w_last;
  logic                              w_stop;
  logic                              w_zero_echo;
  logic                              w_enter_drain;
  logic                              w_short_set;
  logic                              w_ovl_set;
  logic [ECHO_CNT_WIDTH-1:0]         w_num_use;
  logic [ECHO_CNT_WIDTH-1:0]         w_idx_inc;
  logic                              w_train_end;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_rise      = i_acq_wnd & ~r_wnd_prev;
  assign w_decim_in  = DECIM_WIDTH'(eff_decim(32'(i_decim)));
  // The stride is taken straight from the input when sampling starts in the rise cycle.
  assign w_decim     = w_idle ? w_decim_in : r_decim;

  // In truncating mode a low window kills the strobe in the very cycle it is seen low.
  assign w_cut       = (r_state == ST_ACQ) & r_trunc & ~i_acq_wnd;
  assign w_abort_dly = (r_state == ST_DELAY) & r_trunc & ~i_acq_wnd;

  assign w_zero_echo = w_idle & w_rise & (i_samples_per_echo == '0);
  assign w_start     = (w_idle & w_rise & (i_samples_per_echo != '0) & (i_adc_init_delay == '0))
                     | ((r_state == ST_DELAY) & ~w_abort_dly
                        & (r_delay <= ADC_INIT_DELAY_WIDTH'(1)));
  assign w_last      = (r_state == ST_ACQ) & w_strobe & (r_left <= SAMPLES_PER_ECHO_WIDTH'(1));
  assign w_stop      = w_cut | w_last;
  assign w_enter_drain = w_zero_echo | w_abort_dly | w_stop;

  assign w_short_set = ((r_state == ST_DELAY) | (r_state == ST_ACQ)) & ~i_acq_wnd;
  assign w_ovl_set   = w_rise & ~w_idle;

  // The train length is captured at the first echo; a zero-sample first echo ends in the
  // same edge it starts, so it must see the live input.
  assign w_num_use   = (w_idle && (r_echo_idx == '0)) ? i_num_echoes : r_num;
  assign w_idx_inc   = r_echo_idx + ECHO_CNT_WIDTH'(1);
  assign w_train_end = (w_num_use != '0) & (w_idx_inc == w_num_use);

  adc_acq_strobe_gen #(
    .DECIM_WIDTH (DECIM_WIDTH)
  ) u_strobe_gen (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (w_start),
    .i_decim  (w_decim),
    .i_stop   (w_stop),
    .o_strobe (w_strobe)
  );

  // Echo sequencing FSM with echo counting, sticky fault flags and status registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      // Tracking the window through reset keeps a window held high from looking like a rise.
      r_wnd_prev    <= i_acq_wnd;
      r_delay       <= '0;
      r_left        <= '0;
      r_decim       <= '0;
      r_trunc       <= 1'b0;
      r_num         <= '0;
      r_echo_idx    <= '0;
      r_echo_done   <= 1'b0;
      r_train_done  <= 1'b0;
      r_gate        <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_overlap <= 1'b0;
    end else begin
      r_wnd_prev    <= i_acq_wnd;
      r_err_short   <= w_short_set | (r_err_short & ~i_err_clr);
      r_err_overlap <= w_ovl_set | (r_err_overlap & ~i_err_clr);

      if (w_enter_drain) begin
        r_echo_done  <= 1'b1;
        r_train_done <= w_train_end;
        r_echo_idx   <= w_train_end ? '0 : w_idx_inc;
      end else begin
        r_echo_done  <= 1'b0;
        r_train_done <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_trunc <= i_trunc_mode;
            r_decim <= w_decim_in;
            r_left  <= i_samples_per_echo;
            r_delay <= i_adc_init_delay;
            if (r_echo_idx == '0) begin
              r_num <= i_num_echoes;
            end else begin
              r_num <= r_num;
            end
            if (i_samples_per_echo == '0) begin
              r_state <= ST_DRAIN;
            end else if (i_adc_init_delay == '0) begin
              r_state <= ST_ACQ;
              r_gate  <= 1'b1;
            end else begin
              r_state <= ST_DELAY;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (w_abort_dly) begin
            r_state <= ST_DRAIN;
          end else if (w_start) begin
            r_state <= ST_ACQ;
            r_gate  <= 1'b1;
          end else begin
            r_delay <= r_delay - ADC_INIT_DELAY_WIDTH'(1);
          end
        end
        ST_ACQ: begin
          if (w_stop) begin
            r_state <= ST_DRAIN;
            r_gate  <= 1'b0;
          end else if (w_strobe) begin
            r_left <= r_left - SAMPLES_PER_ECHO_WIDTH'(1);
          end else begin
            r_left <= r_left;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_gate  <= 1'b0;
        end
      endcase
    end
  end

  assign o_acq_en        = w_strobe & ~w_cut;
  assign o_acq_gate      = r_gate & ~w_cut;
  assign o_busy          = ~w_idle;
  assign o_echo_done     = r_echo_done;
  assign o_train_done    = r_train_done;
  assign o_echo_idx      = r_echo_idx;
  assign o_err_short_wnd = r_err_short;
  assign o_err_overlap   = r_err_overlap;

endmodule

// File: tb/tb_adc_acq_wingen_mc.sv
// Bench for adc_acq_wingen_mc: directed scenarios followed by randomized windows, all
// checked cycle by cycle against a timeline model of each echo.
module tb_adc_acq_wingen_mc;

  logic        clk = 1'b0;
  logic        rst, wnd, errclr, trunc;
  logic [31:0] dly, spe;
  logic [7:0]  dec;
  logic [15:0] ne;
  logic        en, gate, busy, edone, tdone, eshort, eovl;
  logic [15:0] idx;

  int n_assert = 0;
  int n_fail   = 0;
  int n_seen, n_done, n_train;
  bit scramble = 1'b0;

  // Timeline model: one echo described by its rise cycle and derived key cycles.
  int          cyc = 0;
  bit          m_prev = 1'b0, m_act = 1'b0, m_trunc = 1'b0, m_short = 1'b0, m_ovl = 1'b0;
  int          m_t, m_first, m_last, m_done, m_cut, m_dec;
  logic [15:0] m_idx = 16'd0, m_num = 16'd0;

  always #5 clk = ~clk;

  adc_acq_wingen_mc dut (
    .i_clk              (clk),
    .i_reset            (rst),
    .i_adc_init_delay   (dly),
    .i_samples_per_echo (spe),
    .i_decim            (dec),
    .i_num_echoes       (ne),
    .i_trunc_mode       (trunc),
    .i_err_clr          (errclr),
    .i_acq_wnd          (wnd),
    .o_acq_en           (en),
    .o_acq_gate         (gate),
    .o_busy             (busy),
    .o_echo_done        (edone),
    .o_train_done       (tdone),
    .o_echo_idx         (idx),
    .o_err_short_wnd    (eshort),
    .o_err_overlap      (eovl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: inputs are already applied; outputs are checked mid-cycle.
  task automatic step();
    bit          rise, idle, s_set, o_set, e_en, e_gate, e_busy, e_done, e_train;
    logic [15:0] inc;
    if (scramble) begin
      dly    = $urandom_range(0, 5);
      spe    = $urandom_range(0, 8);
      dec    = 8'($urandom_range(0, 4));
      trunc  = 1'($urandom_range(0, 1));
      ne     = 16'($urandom_range(0, 3));
      errclr = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    rise  = wnd && !m_prev;
    idle  = !m_act || (cyc > m_done);
    s_set = 1'b0;
    o_set = 1'b0;
    if (rise && idle) begin
      m_act   = 1'b1;
      m_t     = cyc;
      m_trunc = trunc;
      m_dec   = (dec == 8'd0) ? 1 : int'(dec);
      m_cut   = 1 << 30;
      if (m_idx == 16'd0) m_num = ne;
      if (spe == 32'd0) begin
        m_first = cyc + 1;
        m_last  = cyc;
        m_done  = cyc + 1;
      end else begin
        m_first = cyc + 1 + int'(dly);
        m_last  = m_first + (int'(spe) - 1) * m_dec;
        m_done  = m_last + 1;
      end
    end else if (rise) begin
      o_set = 1'b1;
    end
    if (m_act && cyc > m_t && cyc <= m_last && cyc < m_cut && !wnd) begin
      s_set = 1'b1;
      if (m_trunc) begin
        m_cut  = cyc;
        m_done = cyc + 1;
      end
    end
    e_gate  = m_act && cyc >= m_first && cyc <= m_last && cyc < m_cut;
    e_en    = e_gate && (((cyc - m_first) % m_dec) == 0);
    e_busy  = m_act && cyc > m_t && cyc <= m_done;
    e_done  = m_act && cyc == m_done;
    e_train = 1'b0;
    if (e_done) begin
      inc = m_idx + 16'd1;
      if (m_num != 16'd0 && inc == m_num) begin
        e_train = 1'b1;
        m_idx   = 16'd0;
      end else begin
        m_idx = inc;
      end
    end
    chk("acq_en",    32'(en),     32'(e_en));
    chk("acq_gate",  32'(gate),   32'(e_gate));
    chk("busy",      32'(busy),   32'(e_busy));
    chk("echo_done", 32'(edone),  32'(e_done));
    chk("train_done",32'(tdone),  32'(e_train));
    chk("echo_idx",  32'(idx),    32'(m_idx));
    chk("err_short", 32'(eshort), 32'(m_short));
    chk("err_ovl",   32'(eovl),   32'(m_ovl));
    n_seen  += int'(en);
    n_done  += int'(edone);
    n_train += int'(tdone);
    if (rst) begin
      m_act   = 1'b0;
      m_idx   = 16'd0;
      m_num   = 16'd0;
      m_short = 1'b0;
      m_ovl   = 1'b0;
    end else begin
      m_short = s_set | (m_short & !errclr);
      m_ovl   = o_set | (m_ovl & !errclr);
    end
    m_prev = wnd;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_seen  = 0;
    n_done  = 0;
    n_train = 0;
  endtask

  initial begin
    rst = 1'b1; wnd = 1'b0; errclr = 1'b0; trunc = 1'b0;
    dly = 32'd0; spe = 32'd0; dec = 8'd1; ne = 16'd0;
    clr_counts();
    @(posedge clk);
    #1;
    // Reset state
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();

    // Baseline two-echo train
    dly = 32'd2; spe = 32'd10; dec = 8'd1; ne = 16'd2; trunc = 1'b0;
    clr_counts();
    wnd = 1'b1; repeat (100) step();
    wnd = 1'b0; repeat (3) step();
    chk("base_strobes", 32'(n_seen), 32'd10);
    chk("base_idx1", 32'(idx), 32'd1);
    clr_counts();
    wnd = 1'b1; repeat (30) step();
    wnd = 1'b0; repeat (3) step();
    chk("base_train", 32'(n_train), 32'd1);
    chk("base_idx0", 32'(idx), 32'd0);

    // Decimated strobes
    dly = 32'd0; spe = 32'd4; dec = 8'd3; ne = 16'd0;
    clr_counts();
    wnd = 1'b1; repeat (15) step();
    wnd = 1'b0; repeat (3) step();
    chk("decim_strobes", 32'(n_seen), 32'd4);

    // Truncation, then error clear
    trunc = 1'b1; dly = 32'd2; spe = 32'd10; dec = 8'd1;
    clr_counts();
    wnd = 1'b1; repeat (6) step();
    wnd = 1'b0; repeat (5) step();
    chk("trunc_strobes", 32'(n_seen), 32'd3);
    chk("trunc_done", 32'(n_done), 32'd1);
    chk("trunc_short", 32'(eshort), 32'd1);
    errclr = 1'b1; step();
    errclr = 1'b0; step();
    chk("trunc_clr", 32'(eshort), 32'd0);

    // Overlapping rise in non-truncating mode
    trunc = 1'b0; spe = 32'd20;
    clr_counts();
    wnd = 1'b1; repeat (5) step();
    wnd = 1'b0; repeat (2) step();
    wnd = 1'b1; repeat (30) step();
    wnd = 1'b0; repeat (3) step();
    chk("ovl_strobes", 32'(n_seen), 32'd20);
    chk("ovl_done", 32'(n_done), 32'd1);
    chk("ovl_flag", 32'(eovl), 32'd1);
    chk("ovl_short", 32'(eshort), 32'd1);
    errclr = 1'b1; step();
    errclr = 1'b0; step();

    // Zero-sample echo
    spe = 32'd0;
    clr_counts();
    wnd = 1'b1; step();
    wnd = 1'b0; repeat (3) step();
    chk("s0_done", 32'(n_done), 32'd1);
    chk("s0_strobes", 32'(n_seen), 32'd0);

    // Zero stride acts as one
    dly = 32'd1; spe = 32'd5; dec = 8'd0;
    clr_counts();
    wnd = 1'b1; repeat (10) step();
    wnd = 1'b0; repeat (3) step();
    chk("d0_strobes", 32'(n_seen), 32'd5);

    // Unbounded train over three echoes
    rst = 1'b1; step();
    rst = 1'b0; step();
    ne = 16'd0; spe = 32'd2; dly = 32'd0; dec = 8'd1;
    clr_counts();
    repeat (3) begin
      wnd = 1'b1; repeat (5) step();
      wnd = 1'b0; repeat (2) step();
    end
    chk("unb_idx", 32'(idx), 32'd3);
    chk("unb_train", 32'(n_train), 32'd0);

    // Reset in the cycle of the fifth strobe
    spe = 32'd10;
    wnd = 1'b1; repeat (5) step();
    rst = 1'b1; wnd = 1'b0; step();
    rst = 1'b0; step();
    chk("rst_idx", 32'(idx), 32'd0);
    clr_counts();
    wnd = 1'b1; repeat (15) step();
    wnd = 1'b0; repeat (3) step();
    chk("rst_fresh_strobes", 32'(n_seen), 32'd10);
    chk("rst_fresh_idx", 32'(idx), 32'd1);

    // Randomized windows with parameters changing every cycle
    scramble = 1'b1;
    repeat (60) begin
      wnd = 1'b1; repeat ($urandom_range(1, 30)) step();
      wnd = 1'b0; repeat ($urandom_range(1, 8)) step();
    end
    scramble = 1'b0;
    errclr   = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
